// File: rtl/aha_sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
//   NUM_PORTS          : number of requesters sharing the SRAM port
//   ADDR_W_DEF         : default word-address width (4096 words)
//   DATA_W_DEF         : default data width (must be a multiple of 8)
//   port_state_e       : per-requester sequencing state
//   sram_req_t         : one request {write, addr, wdata, strb} at default widths
package aha_sram_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned STRB_W_DEF = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    StIdle,
    StInflight,
    StResp
  } port_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [STRB_W_DEF-1:0] strb;
  } sram_req_t;

endpackage

// File: rtl/aha_sram32k_arbiter_if.sv
// Request/response channel of one SRAM requester.
//   REQ_VALID/REQ_READY : request handshake (fires on VALID & READY)
//   REQ_WRITE           : 1 = write, 0 = read
//   REQ_ADDR/WDATA/STRB : word address, write data, active-high byte strobes
//   RSP_VALID/RSP_READY : response handshake (fires on VALID & READY)
//   RSP_RDATA           : read data, 0 for write responses
// Modports: master = requester side, slave = arbiter side.
interface aha_sram32k_arbiter_if import aha_sram_arb_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WRITE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic [STRB_W-1:0] REQ_STRB;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_RDATA;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA
  );

endinterface

// File: rtl/aha_sram_arb_port.sv
// Per-requester sequencer: IDLE -> INFLIGHT (SRAM access) -> RESP (hold response).
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_accept        : request granted and accepted this cycle
//   i_write         : accepted request is a write
//   i_rsp_ready     : requester consumes the response
//   i_sram_q        : SRAM read data, valid during the INFLIGHT cycle
//   o_eligible      : port may accept a new request this cycle
//   o_rsp_valid     : response valid
//   o_rsp_rdata     : captured read data (0 for writes), held until consumed
module aha_sram_arb_port import aha_sram_arb_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_accept,
  input  logic              i_write,
  input  logic              i_rsp_ready,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic              o_eligible,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata
);

  port_state_e       r_state, w_state_next;
  logic              r_write, w_write_next;
  logic [DATA_W-1:0] r_rdata, w_rdata_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_write <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_write <= w_write_next;
      r_rdata <= w_rdata_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_write_next = r_write;
    w_rdata_next = r_rdata;
    unique case (r_state)
      StIdle: begin
        if (i_accept) begin
          w_state_next = StInflight;
          w_write_next = i_write;
        end
      end
      StInflight: begin
        w_state_next = StResp;
        w_rdata_next = r_write ? '0 : i_sram_q;
      end
      StResp: begin
        // A same-cycle accept overlaps response fire with the next access.
        if (i_rsp_ready) begin
          if (i_accept) begin
            w_state_next = StInflight;
            w_write_next = i_write;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_eligible  = (r_state == StIdle) || ((r_state == StResp) && i_rsp_ready);
  assign o_rsp_valid = (r_state == StResp);
  assign o_rsp_rdata = r_rdata;

endmodule

// File: rtl/aha_sram32k_arbiter.sv
// Two-requester arbiter/sequencer for the 4K x 64 SRAM wrapper.
//   CLK, RESET      : clock, synchronous active-high reset
//   M0, M1          : requester channels (slave modport)
//   SRAM_CEn        : active-low chip enable
//   SRAM_WEn        : active-low byte write enables
//   SRAM_A, SRAM_D  : address and write data, driven in the accept cycle
//   SRAM_Q          : read data, valid the cycle after an enabled read
// Build option: define AHA_SRAM_ARB_FIXED_PRIO_EN for strict M0 priority;
// default is round-robin.
module aha_sram32k_arbiter import aha_sram_arb_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  aha_sram32k_arbiter_if.slave M0,
  aha_sram32k_arbiter_if.slave M1,
  output logic                SRAM_CEn,
  output logic [DATA_W/8-1:0] SRAM_WEn,
  output logic [ADDR_W-1:0]   SRAM_A,
  output logic [DATA_W-1:0]   SRAM_D,
  input  logic [DATA_W-1:0]   SRAM_Q
);

  logic [NUM_PORTS-1:0] w_valid;
  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_cand;
  logic [NUM_PORTS-1:0] w_grant;

  assign w_valid = {M1.REQ_VALID, M0.REQ_VALID};
  assign w_cand  = w_valid & w_elig;

`ifdef AHA_SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    if (!RESET) begin
      if (w_cand[0])      w_grant = 2'b01;
      else if (w_cand[1]) w_grant = 2'b10;
    end
  end
`else
  // r_ptr names the port that wins a tie: 0 = M0, 1 = M1.
  logic r_ptr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ptr <= 1'b0;
    end else if (|w_grant) begin
      r_ptr <= w_grant[0];
    end
  end

  always_comb begin
    w_grant = '0;
    if (!RESET) begin
      unique case (w_cand)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
        default: w_grant = '0;
      endcase
    end
  end
`endif

  assign M0.REQ_READY = w_grant[0];
  assign M1.REQ_READY = w_grant[1];

  // Grants are suppressed in reset, so the idle drive below also covers reset.
  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = '1;
    SRAM_A   = '0;
    SRAM_D   = '0;
    if (w_grant[0]) begin
      SRAM_CEn = 1'b0;
      SRAM_WEn = M0.REQ_WRITE ? ~M0.REQ_STRB : '1;
      SRAM_A   = M0.REQ_ADDR;
      SRAM_D   = M0.REQ_WDATA;
    end else if (w_grant[1]) begin
      SRAM_CEn = 1'b0;
      SRAM_WEn = M1.REQ_WRITE ? ~M1.REQ_STRB : '1;
      SRAM_A   = M1.REQ_ADDR;
      SRAM_D   = M1.REQ_WDATA;
    end
  end

  aha_sram_arb_port #(.DATA_W(DATA_W)) u_port0 (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_accept    (w_grant[0]),
    .i_write     (M0.REQ_WRITE),
    .i_rsp_ready (M0.RSP_READY),
    .i_sram_q    (SRAM_Q),
    .o_eligible  (w_elig[0]),
    .o_rsp_valid (M0.RSP_VALID),
    .o_rsp_rdata (M0.RSP_RDATA)
  );

  aha_sram_arb_port #(.DATA_W(DATA_W)) u_port1 (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_accept    (w_grant[1]),
    .i_write     (M1.REQ_WRITE),
    .i_rsp_ready (M1.RSP_READY),
    .i_sram_q    (SRAM_Q),
    .o_eligible  (w_elig[1]),
    .o_rsp_valid (M1.RSP_VALID),
    .o_rsp_rdata (M1.RSP_RDATA)
  );

endmodule

// File: tb/tb_aha_sram32k_arbiter.sv
// Self-checking bench for aha_sram32k_arbiter: directed requests, an SRAM model,
// and a response scoreboard checked by an independent monitor.
module tb_aha_sram32k_arbiter;
  import aha_sram_arb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;

  localparam logic [DW-1:0] D1 = 64'h1122334455667788;
  localparam logic [DW-1:0] DH = 64'h00000000FFFFFFFF;
  localparam logic [DW-1:0] D6 = 64'hCAFEF00D12345678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aha_sram32k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  aha_sram32k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  logic          sram_cen;
  logic [SW-1:0] sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  aha_sram32k_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .M0       (m0_if),
    .M1       (m1_if),
    .SRAM_CEn (sram_cen),
    .SRAM_WEn (sram_wen),
    .SRAM_A   (sram_a),
    .SRAM_D   (sram_d),
    .SRAM_Q   (sram_q)
  );

  // SRAM model: 1-cycle read latency, byte-masked writes.
  bit [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (&sram_wen) sram_q <= mem[sram_a];
      else begin
        for (int b = 0; b < int'(SW); b++)
          if (!sram_wen[b]) mem[sram_a][b*8 +: 8] <= sram_d[b*8 +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor.
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int rsp_cyc [2];
  int rsp_cnt [2];

  always @(negedge clk) begin
    if (m0_if.RSP_VALID && m0_if.RSP_READY) begin
      rsp_cyc[0] = cyc;
      rsp_cnt[0]++;
      if (exp_q0.size() == 0) check("m0_unexpected_rsp", m0_if.RSP_RDATA, 'x);
      else check("m0_rsp_rdata", m0_if.RSP_RDATA, exp_q0.pop_front());
    end
    if (m1_if.RSP_VALID && m1_if.RSP_READY) begin
      rsp_cyc[1] = cyc;
      rsp_cnt[1]++;
      if (exp_q1.size() == 0) check("m1_unexpected_rsp", m1_if.RSP_RDATA, 'x);
      else check("m1_rsp_rdata", m1_if.RSP_RDATA, exp_q1.pop_front());
    end
  end

  // Grant log for the streaming section: {CEn, M1 ready, M0 ready}.
  bit       log_en = 1'b0;
  int       log_n  = 0;
  logic [2:0] log_v [8];
  always @(negedge clk) begin
    if (log_en && log_n < 8) begin
      log_v[log_n] = {sram_cen, m1_if.REQ_READY, m0_if.REQ_READY};
      log_n++;
    end
  end

  // Requester protocol: VALID must stay up until accepted.
  bit pend0, pend1;
  always @(posedge clk) begin
    if (!rst && pend0) assert (m0_if.REQ_VALID) else $error("m0 valid dropped before accept");
    if (!rst && pend1) assert (m1_if.REQ_VALID) else $error("m1 valid dropped before accept");
    pend0 <= m0_if.REQ_VALID && !m0_if.REQ_READY && !rst;
    pend1 <= m1_if.REQ_VALID && !m1_if.REQ_READY && !rst;
  end

  logic          acc_cen;
  logic [SW-1:0] acc_wen;
  logic [AW-1:0] acc_a;
  logic [DW-1:0] acc_d;
  int            acc_cyc [2];

  function automatic sram_req_t mk(input bit wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input logic [SW-1:0] s);
    sram_req_t r;
    r.write = wr;
    r.addr  = a;
    r.wdata = d;
    r.strb  = s;
    return r;
  endfunction

  task automatic drive(input int p, input bit v, input sram_req_t r);
    if (p == 0) begin
      m0_if.REQ_VALID = v;  m0_if.REQ_WRITE = r.write; m0_if.REQ_ADDR = r.addr;
      m0_if.REQ_WDATA = r.wdata; m0_if.REQ_STRB = r.strb;
    end else begin
      m1_if.REQ_VALID = v;  m1_if.REQ_WRITE = r.write; m1_if.REQ_ADDR = r.addr;
      m1_if.REQ_WDATA = r.wdata; m1_if.REQ_STRB = r.strb;
    end
  endtask

  // Present a request, wait (bounded) for accept, push the expected response.
  task automatic issue(input int p, input sram_req_t r, input logic [DW-1:0] exp);
    bit done = 1'b0;
    drive(p, 1'b1, r);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((p == 0) ? m0_if.REQ_READY : m1_if.REQ_READY) begin
        done       = 1'b1;
        acc_cen    = sram_cen;
        acc_wen    = sram_wen;
        acc_a      = sram_a;
        acc_d      = sram_d;
        acc_cyc[p] = cyc;
        if (p == 0) exp_q0.push_back(exp);
        else        exp_q1.push_back(exp);
      end
    end
    if (!done) check($sformatf("accept_timeout_p%0d", p), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    drive(p, 1'b0, r);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++)
      @(negedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a_cyc;
    int n0;
    int n1;
    drive(0, 1'b0, mk(1'b0, '0, '0, '0));
    drive(1, 1'b0, mk(1'b0, '0, '0, '0));
    m0_if.RSP_READY = 1'b1;
    m1_if.RSP_READY = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cen", 64'(sram_cen), 64'd1);
    check("rst_wen", 64'(sram_wen), 64'hFF);
    check("rst_ready", 64'({m1_if.REQ_READY, m0_if.REQ_READY}), 64'd0);
    check("rst_rsp_valid", 64'({m1_if.RSP_VALID, m0_if.RSP_VALID}), 64'd0);
    check("rst_rdata0", m0_if.RSP_RDATA, 64'd0);
    check("rst_rdata1", m1_if.RSP_RDATA, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full write then read of 0x005.
    issue(0, mk(1'b1, 12'h005, D1, 8'hFF), 64'd0);
    check("wr_cen", 64'(acc_cen), 64'd0);
    check("wr_wen", 64'(acc_wen), 64'h00);
    check("wr_addr", 64'(acc_a), 64'h005);
    check("wr_data", acc_d, D1);
    issue(0, mk(1'b0, 12'h005, '0, '0), D1);
    a_cyc = acc_cyc[0];
    check("rd_cen", 64'(acc_cen), 64'd0);
    check("rd_wen", 64'(acc_wen), 64'hFF);
    check("rd_addr", 64'(acc_a), 64'h005);
    drain();
    check("rd_latency", 64'(rsp_cyc[0] - a_cyc), 64'd2);

    // Partial write at the top address, then read back.
    issue(0, mk(1'b1, 12'hFFF, '1, 8'h0F), 64'd0);
    check("pw_wen", 64'(acc_wen), 64'hF0);
    check("pw_addr", 64'(acc_a), 64'hFFF);
    issue(0, mk(1'b0, 12'hFFF, '0, '0), DH);
    drain();

    // Write with no strobes: access happens, nothing is written.
    issue(0, mk(1'b1, 12'h010, 64'hDEADBEEFDEADBEEF, 8'h00), 64'd0);
    check("s0_cen", 64'(acc_cen), 64'd0);
    check("s0_wen", 64'(acc_wen), 64'hFF);
    drain();

    // Both ports streaming reads from a fresh pointer.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = rsp_cnt[0];
    n1 = rsp_cnt[1];
    log_en = 1'b1;
    fork
      begin
        issue(0, mk(1'b0, 12'h005, '0, '0), D1);
        issue(0, mk(1'b0, 12'hFFF, '0, '0), DH);
        issue(0, mk(1'b0, 12'h005, '0, '0), D1);
        issue(0, mk(1'b0, 12'hFFF, '0, '0), DH);
      end
      begin
        issue(1, mk(1'b0, 12'hFFF, '0, '0), DH);
        issue(1, mk(1'b0, 12'h005, '0, '0), D1);
        issue(1, mk(1'b0, 12'h010, '0, '0), 64'd0);
        issue(1, mk(1'b0, 12'h005, '0, '0), D1);
      end
    join
    drain();
    log_en = 1'b0;
    for (int k = 0; k < 8; k++)
      check($sformatf("stream_grant_%0d", k), 64'(log_v[k]),
            (k % 2 == 0) ? 64'b001 : 64'b010);
    check("stream_cnt0", 64'(rsp_cnt[0] - n0), 64'd4);
    check("stream_cnt1", 64'(rsp_cnt[1] - n1), 64'd4);

    // M1 response back-pressure while M0 keeps going.
    n0 = rsp_cnt[0];
    m1_if.RSP_READY = 1'b0;
    issue(1, mk(1'b0, 12'h005, '0, '0), D1);
    fork
      issue(1, mk(1'b0, 12'hFFF, '0, '0), DH);
      begin
        issue(0, mk(1'b0, 12'h005, '0, '0), D1);
        issue(0, mk(1'b0, 12'hFFF, '0, '0), DH);
        issue(0, mk(1'b0, 12'h010, '0, '0), 64'd0);
      end
      begin
        for (int k = 0; k < 10 && !m1_if.RSP_VALID; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          check($sformatf("bp_valid_%0d", i), 64'(m1_if.RSP_VALID), 64'd1);
          check($sformatf("bp_rdata_%0d", i), m1_if.RSP_RDATA, D1);
          check($sformatf("bp_ready_%0d", i), 64'(m1_if.REQ_READY), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 m1_if.RSP_READY = 1'b1;
        @(negedge clk);
        check("bp_release_accept", 64'({m1_if.REQ_READY, m1_if.RSP_VALID}), 64'b11);
      end
    join
    drain();
    check("bp_m0_served", 64'(rsp_cnt[0] - n0), 64'd3);

    // Reset the cycle after an M0 read accept: the response is discarded.
    issue(0, mk(1'b0, 12'h005, '0, '0), D1);
    rst = 1'b1;
    exp_q0.delete();
    @(negedge clk);
    check("mid_rst_cen", 64'(sram_cen), 64'd1);
    check("mid_rst_wen", 64'(sram_wen), 64'hFF);
    check("mid_rst_ready", 64'({m1_if.REQ_READY, m0_if.REQ_READY}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_valid_%0d", i), 64'(m0_if.RSP_VALID), 64'd0);
    end
    check("post_rst_rdata", m0_if.RSP_RDATA, 64'd0);
    @(posedge clk);
    #1;
    issue(0, mk(1'b0, 12'hFFF, '0, '0), DH);
    drain();

    // M0 write then M1 read of the same address on the next cycle.
    fork
      issue(0, mk(1'b1, 12'h800, D6, 8'hFF), 64'd0);
      begin
        @(posedge clk);
        #1;
        issue(1, mk(1'b0, 12'h800, '0, '0), D6);
      end
    join
    check("hazard_order", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
